// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode/execute hazard signals between the pipeline and hazard_ctrl
interface hazard_ctrl_if #(
  parameter int CNTW = 16
);
  logic [3:0]      RA1D;
  logic [3:0]      RA2D;
  logic [3:0]      WA3D;
  logic            RegWriteD;
  logic            MemtoRegD;
  logic            PCSrcD;
  logic            BranchTakenE;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic            FlushE;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  modport master (
    output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
  );

  modport slave (
    input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard control: forwarding, load-use/PC-write stalls, flushes, perf counters
module hazard_ctrl #(
  parameter int CNTW = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  logic [3:0]      ra1e, ra2e, wa3e;
  logic            regwritee, memtorege, pcsrce;
  logic [3:0]      wa3m;
  logic            regwritem, pcsrcm;
  logic [3:0]      wa3w;
  logic            regwritew, pcsrcw;
  logic            ldrstall;
  logic            pcwrpend;
  logic            flush_e_int;
  logic [CNTW-1:0] stall_cnt_q;
  logic [CNTW-1:0] flush_cnt_q;

  // R15 reads come from the PC+8 path, so they never take a forwarded value.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] wm,
    input logic       rwm,
    input logic [3:0] ww,
    input logic       rww
  );
    if (ra == 4'd15)
      return 2'b00;
    else if (rwm && (wm == ra))
      return 2'b10;
    else if (rww && (ww == ra))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ldrstall    = memtorege & regwritee & ((wa3e == hz.RA1D) | (wa3e == hz.RA2D));
  assign pcwrpend    = hz.PCSrcD | pcsrce | pcsrcm;
  assign flush_e_int = ldrstall | hz.BranchTakenE;

  always_ff @(posedge clk) begin
    if (reset) begin
      ra1e      <= 4'd0;
      ra2e      <= 4'd0;
      wa3e      <= 4'd0;
      regwritee <= 1'b0;
      memtorege <= 1'b0;
      pcsrce    <= 1'b0;
      wa3m      <= 4'd0;
      regwritem <= 1'b0;
      pcsrcm    <= 1'b0;
      wa3w      <= 4'd0;
      regwritew <= 1'b0;
      pcsrcw    <= 1'b0;
    end else begin
      if (flush_e_int) begin
        ra1e      <= 4'd0;
        ra2e      <= 4'd0;
        wa3e      <= 4'd0;
        regwritee <= 1'b0;
        memtorege <= 1'b0;
        pcsrce    <= 1'b0;
      end else begin
        ra1e      <= hz.RA1D;
        ra2e      <= hz.RA2D;
        wa3e      <= hz.WA3D;
        regwritee <= hz.RegWriteD;
        memtorege <= hz.MemtoRegD;
        pcsrce    <= hz.PCSrcD;
      end
      wa3m      <= wa3e;
      regwritem <= regwritee;
      pcsrcm    <= pcsrce;
      wa3w      <= wa3m;
      regwritew <= regwritem;
      pcsrcw    <= pcsrcm;
    end
  end

  // While in reset both pipeline registers are forced to bubbles.
  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.FlushD    = 1'b1;
    hz.FlushE    = 1'b1;
    if (!reset) begin
      hz.ForwardAE = fwd_sel(ra1e, wa3m, regwritem, wa3w, regwritew);
      hz.ForwardBE = fwd_sel(ra2e, wa3m, regwritem, wa3w, regwritew);
      hz.StallD    = ldrstall;
      hz.StallF    = ldrstall | pcwrpend;
      hz.FlushE    = flush_e_int;
      hz.FlushD    = pcwrpend | pcsrcw | hz.BranchTakenE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ldrstall && (stall_cnt_q != {CNTW{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_e_int && (flush_cnt_q != {CNTW{1'b1}}))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule
